exception_ctrl: RTL and testbench

- Commit-side exception controller for the dual-issue pipeline; sits directly upstream of the CP0 register file.
- Each cycle it takes the two committing slots from MEM, together with the CP0 status/cause/epc/ebase state, and selects at most one exception or ERET.
- It drives the CP0 exception inputs through registers, flushes the pipeline, and delivers the redirect PC to fetch over a valid/ready handshake.
- It also synchronises the six external hardware interrupt lines that feed CP0's interrupt input.

---
 rtl/exception_ctrl_pkg.sv | 36 +++
 rtl/exception_ctrl_int_sync.sv | 30 +++
 rtl/exception_ctrl.sv | 162 ++++++++++++++++
 tb/tb_exception_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exception_ctrl_pkg.sv
// Shared definitions for the commit-side exception controller:
// CP0 exception codes, exception-vector bit positions, FSM state encoding.
// Imported by exception_ctrl and its sub-modules.
package exception_ctrl_pkg;

    // CP0 ExcCode values driven on exception_type_o
    localparam logic [4:0] EXCEPTION_INT  = 5'd0;
    localparam logic [4:0] EXCEPTION_ADEL = 5'd4;
    localparam logic [4:0] EXCEPTION_ADES = 5'd5;
    localparam logic [4:0] EXCEPTION_SYS  = 5'd8;
    localparam logic [4:0] EXCEPTION_BP   = 5'd9;
    localparam logic [4:0] EXCEPTION_RI   = 5'd10;
    localparam logic [4:0] EXCEPTION_OV   = 5'd12;
    localparam logic [4:0] EXCEPTION_TR   = 5'd13;
    localparam logic [4:0] EXCEPTION_ERET = 5'd14;

    // Bit positions inside each per-slot exception vector
    localparam int EXC_BIT_ADEL_IF = 0;
    localparam int EXC_BIT_RI      = 1;
    localparam int EXC_BIT_SYS     = 2;
    localparam int EXC_BIT_BP      = 3;
    localparam int EXC_BIT_OV      = 4;
    localparam int EXC_BIT_TR      = 5;
    localparam int EXC_BIT_ADEL_D  = 6;
    localparam int EXC_BIT_ADES_D  = 7;
    localparam int EXC_BIT_ERET    = 8;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

endpackage

// File: rtl/exception_ctrl_int_sync.sv
// Multi-flop synchroniser for asynchronous interrupt lines.
// Ports: clk/rst (async active-low), d_i raw lines, q_o synchronised lines.
// Latency: STAGES clock edges from d_i to q_o; no backpressure.
module int_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/exception_ctrl.sv
// Commit-side exception controller: picks at most one exception/ERET from two
// committing slots, drives CP0 exception inputs, flushes, then redirects fetch.
// Latency: CP0 outputs + flush one edge after commit; redirect one edge later, held until ready.
module exception_ctrl
    import exception_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int EXC_W       = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       int_i,
    output logic [5:0]       int_sync_o,
    input  logic             slot1_valid_i,
    input  logic             slot2_valid_i,
    input  logic [31:0]      slot1_pc_i,
    input  logic [31:0]      slot2_pc_i,
    input  logic             slot1_ds_i,
    input  logic             slot2_ds_i,
    input  logic [EXC_W-1:0] slot1_exc_i,
    input  logic [EXC_W-1:0] slot2_exc_i,
    input  logic [31:0]      mem_addr_i,
    input  logic [31:0]      status_i,
    input  logic [31:0]      cause_i,
    input  logic [31:0]      epc_i,
    input  logic [31:0]      ebase_i,
    output logic             exception_flag_o,
    output logic [4:0]       exception_type_o,
    output logic             exception_first_inst_o,
    output logic [31:0]      inst1_addr_o,
    output logic [31:0]      inst2_addr_o,
    output logic [31:0]      mem_addr_o,
    output logic             is_in_delayslot1_o,
    output logic             is_in_delayslot2_o,
    output logic             flush_o,
    output logic             busy_o,
    output logic             redirect_valid_o,
    output logic [31:0]      redirect_pc_o,
    input  logic             redirect_ready_i
);

    int_sync #(.STAGES(SYNC_STAGES), .WIDTH(6)) u_int_sync (
        .clk (clk),
        .rst (rst),
        .d_i (int_i),
        .q_o (int_sync_o)
    );

    // Fixed-priority encoder within one slot; an ERET-only vector falls through to ERET.
    function automatic logic [4:0] pick_code(input logic intr, input logic [EXC_W-1:0] e);
        if (intr)                      return EXCEPTION_INT;
        else if (e[EXC_BIT_ADEL_IF])   return EXCEPTION_ADEL;
        else if (e[EXC_BIT_RI])        return EXCEPTION_RI;
        else if (e[EXC_BIT_SYS])       return EXCEPTION_SYS;
        else if (e[EXC_BIT_BP])        return EXCEPTION_BP;
        else if (e[EXC_BIT_OV])        return EXCEPTION_OV;
        else if (e[EXC_BIT_TR])        return EXCEPTION_TR;
        else if (e[EXC_BIT_ADEL_D])    return EXCEPTION_ADEL;
        else if (e[EXC_BIT_ADES_D])    return EXCEPTION_ADES;
        else                           return EXCEPTION_ERET;
    endfunction

    logic       int_pend;
    logic       s1_int, s2_int;
    logic       s1_hit_d, s2_hit_d;
    logic       exc_sel_d;
    logic [4:0] sel_code_d;

    // Interrupts only when IE=1 and EXL=0, and some unmasked cause bit is set.
    assign int_pend = status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8]));

    // The interrupt rides on the oldest committing slot; with none it stays pending.
    assign s1_int   = int_pend & slot1_valid_i;
    assign s2_int   = int_pend & ~slot1_valid_i & slot2_valid_i;

    assign s1_hit_d   = slot1_valid_i & (s1_int | (|slot1_exc_i));
    assign s2_hit_d   = slot2_valid_i & (s2_int | (|slot2_exc_i));
    assign exc_sel_d  = s1_hit_d | s2_hit_d;
    assign sel_code_d = s1_hit_d ? pick_code(s1_int, slot1_exc_i)
                                 : pick_code(s2_int, slot2_exc_i);

    logic unused_cp0_bits;
    assign unused_cp0_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

    state_e      state_q;
    logic        flag_q, first_q, ds1_q, ds2_q, flush_q, busy_q, rv_q;
    logic [4:0]  type_q;
    logic [31:0] inst1_q, inst2_q, maddr_q, rpc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            flag_q  <= 1'b0;
            type_q  <= 5'd0;
            first_q <= 1'b0;
            inst1_q <= ZeroWord;
            inst2_q <= ZeroWord;
            maddr_q <= ZeroWord;
            ds1_q   <= 1'b0;
            ds2_q   <= 1'b0;
            flush_q <= 1'b0;
            busy_q  <= 1'b0;
            rv_q    <= 1'b0;
            rpc_q   <= ZeroWord;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (exc_sel_d) begin
                        flag_q  <= 1'b1;
                        type_q  <= sel_code_d;
                        first_q <= s1_hit_d;
                        inst1_q <= slot1_pc_i;
                        inst2_q <= slot2_pc_i;
                        maddr_q <= mem_addr_i;
                        ds1_q   <= slot1_ds_i;
                        ds2_q   <= slot2_ds_i;
                        flush_q <= 1'b1;
                        busy_q  <= 1'b1;
                        rpc_q   <= (sel_code_d == EXCEPTION_ERET) ? epc_i : ebase_i;
                        state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    // CP0 strobe and flush are single-cycle pulses.
                    flag_q  <= 1'b0;
                    type_q  <= 5'd0;
                    first_q <= 1'b0;
                    inst1_q <= ZeroWord;
                    inst2_q <= ZeroWord;
                    maddr_q <= ZeroWord;
                    ds1_q   <= 1'b0;
                    ds2_q   <= 1'b0;
                    flush_q <= 1'b0;
                    rv_q    <= 1'b1;
                    state_q <= ST_REDIRECT;
                end
                ST_REDIRECT: begin
                    if (rv_q && redirect_ready_i) begin
                        rv_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign exception_flag_o       = flag_q;
    assign exception_type_o       = type_q;
    assign exception_first_inst_o = first_q;
    assign inst1_addr_o           = inst1_q;
    assign inst2_addr_o           = inst2_q;
    assign mem_addr_o             = maddr_q;
    assign is_in_delayslot1_o     = ds1_q;
    assign is_in_delayslot2_o     = ds2_q;
    assign flush_o                = flush_q;
    assign busy_o                 = busy_q;
    assign redirect_valid_o       = rv_q;
    assign redirect_pc_o          = rpc_q;

endmodule

// File: tb/tb_exception_ctrl.sv
module tb_exception_ctrl;

    logic        clk, rst;
    logic [5:0]  int_i, int_sync_o;
    logic        slot1_valid_i, slot2_valid_i, slot1_ds_i, slot2_ds_i;
    logic [31:0] slot1_pc_i, slot2_pc_i, mem_addr_i, status_i, cause_i, epc_i, ebase_i;
    logic [8:0]  slot1_exc_i, slot2_exc_i;
    logic        exception_flag_o, exception_first_inst_o;
    logic [4:0]  exception_type_o;
    logic [31:0] inst1_addr_o, inst2_addr_o, mem_addr_o, redirect_pc_o;
    logic        is_in_delayslot1_o, is_in_delayslot2_o, flush_o, busy_o;
    logic        redirect_valid_o, redirect_ready_i;

    exception_ctrl #(.SYNC_STAGES(2), .EXC_W(9)) dut (
        .clk(clk), .rst(rst), .int_i(int_i), .int_sync_o(int_sync_o),
        .slot1_valid_i(slot1_valid_i), .slot2_valid_i(slot2_valid_i),
        .slot1_pc_i(slot1_pc_i), .slot2_pc_i(slot2_pc_i),
        .slot1_ds_i(slot1_ds_i), .slot2_ds_i(slot2_ds_i),
        .slot1_exc_i(slot1_exc_i), .slot2_exc_i(slot2_exc_i),
        .mem_addr_i(mem_addr_i), .status_i(status_i), .cause_i(cause_i),
        .epc_i(epc_i), .ebase_i(ebase_i),
        .exception_flag_o(exception_flag_o), .exception_type_o(exception_type_o),
        .exception_first_inst_o(exception_first_inst_o),
        .inst1_addr_o(inst1_addr_o), .inst2_addr_o(inst2_addr_o), .mem_addr_o(mem_addr_o),
        .is_in_delayslot1_o(is_in_delayslot1_o), .is_in_delayslot2_o(is_in_delayslot2_o),
        .flush_o(flush_o), .busy_o(busy_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .redirect_ready_i(redirect_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  code;
        logic        first;
        logic [31:0] pc1, pc2, maddr, rpc;
        logic        ds1, ds2;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0 ] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference priority encoder with literal CP0 codes.
    function automatic logic [4:0] ref_code(input logic ip, input logic [8:0] e);
        if (ip)        return 5'd0;
        if (e[0])      return 5'd4;
        if (e[1])      return 5'd10;
        if (e[2])      return 5'd8;
        if (e[3])      return 5'd9;
        if (e[4])      return 5'd12;
        if (e[5])      return 5'd13;
        if (e[6])      return 5'd4;
        if (e[7])      return 5'd5;
        return 5'd14;
    endfunction

    // Present the currently driven slots for one commit cycle and record the expectation.
    task automatic fire();
        logic ip, s1x, s2x;
        exp_t e;
        ip  = status_i[0] && !status_i[1] && ((cause_i[15:8] & status_i[15:8]) != 8'h0);
        s1x = slot1_valid_i && (ip || slot1_exc_i != 9'h0);
        s2x = slot2_valid_i && ((ip && !slot1_valid_i) || slot2_exc_i != 9'h0);
        if (s1x || s2x) begin
            e.code  = s1x ? ref_code(ip, slot1_exc_i) : ref_code(ip && !slot1_valid_i, slot2_exc_i);
            e.first = s1x;
            e.pc1   = slot1_pc_i;
            e.pc2   = slot2_pc_i;
            e.ds1   = slot1_ds_i;
            e.ds2   = slot2_ds_i;
            e.maddr = mem_addr_i;
            e.rpc   = (e.code == 5'd14) ? epc_i : ebase_i;
            sb.push_back(e);
        end
        @(negedge clk);
        slot1_valid_i = 1'b0;
        slot2_valid_i = 1'b0;
    endtask

    task automatic expect_none(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            chk("no_flush", {31'd0, flush_o}, 32'd0);
            chk("no_flag", {31'd0, exception_flag_o}, 32'd0);
            @(negedge clk);
        end
    endtask

    // Pop the expected exception, check CP0 strobe, then run the redirect handshake.
    task automatic expect_exc(input int delay, input bit inject_sys);
        exp_t e;
        int   held;
        bit   done;
        chk("sb_pending", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() == 0) return;
        for (int c = 0; c < 4 && !flush_o; c++) @(negedge clk);
        chk("flush", {31'd0, flush_o}, 32'd1);
        e = sb.pop_front();
        chk("flag",  {31'd0, exception_flag_o}, 32'd1);
        chk("type",  {27'd0, exception_type_o}, {27'd0, e.code});
        chk("first", {31'd0, exception_first_inst_o}, {31'd0, e.first});
        chk("pc1",   inst1_addr_o, e.pc1);
        chk("pc2",   inst2_addr_o, e.pc2);
        chk("ds1",   {31'd0, is_in_delayslot1_o}, {31'd0, e.ds1});
        chk("ds2",   {31'd0, is_in_delayslot2_o}, {31'd0, e.ds2});
        chk("maddr", mem_addr_o, e.maddr);
        chk("busy",  {31'd0, busy_o}, 32'd1);
        redirect_ready_i = 1'b0;
        held = 0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (redirect_valid_o) begin
                held++;
                chk("rpc", redirect_pc_o, e.rpc);
                chk("flag_low", {31'd0, exception_flag_o | flush_o}, 32'd0);
                if (held > delay) begin
                    redirect_ready_i = 1'b1;
                    slot1_valid_i    = 1'b0;
                end else if (inject_sys) begin
                    slot1_valid_i = 1'b1;
                    slot1_exc_i   = 9'b000000100;
                end
            end else if (held > 0) begin
                done = 1'b1;
            end
        end
        chk("redirect_done", {31'd0, done}, 32'd1);
        redirect_ready_i = 1'b0;
        chk("held_cycles", held, delay + 1);
        chk("busy_clear", {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; int_i = 6'b111111;
        slot1_valid_i = 0; slot2_valid_i = 0; slot1_ds_i = 0; slot2_ds_i = 0;
        slot1_pc_i = 0; slot2_pc_i = 0; slot1_exc_i = 0; slot2_exc_i = 0;
        mem_addr_i = 0; status_i = 0; cause_i = 0; epc_i = 0; ebase_i = 32'hBFC0_0380;
        redirect_ready_i = 0;

        // Reset: everything quiet despite toggling inputs
        repeat (3) begin
            @(negedge clk);
            chk("rst_ctl", {20'd0, exception_flag_o, exception_type_o, exception_first_inst_o,
                is_in_delayslot1_o, is_in_delayslot2_o, flush_o, busy_o, redirect_valid_o}, 32'd0);
            chk("rst_addr", inst1_addr_o | inst2_addr_o | mem_addr_o | redirect_pc_o, 32'd0);
            chk("rst_sync", {26'd0, int_sync_o}, 32'd0);
        end
        int_i = 6'b000000;
        rst   = 1'b1;
        @(negedge clk);
        int_i = 6'b000100;
        @(negedge clk);
        chk("sync_1edge", {26'd0, int_sync_o}, 32'd0);
        @(negedge clk);
        chk("sync_2edge", {26'd0, int_sync_o}, 32'h4);

        // Slot1 SYSCALL, immediate ready
        slot1_valid_i = 1; slot1_pc_i = 32'hBFC0_0100; slot1_exc_i = 9'b000000100; slot1_ds_i = 0;
        slot2_pc_i = 32'hBFC0_0104; mem_addr_i = 32'h0000_1230;
        fire();
        expect_exc(0, 0);
        expect_none(2);

        // Both slots fault: slot1 RI beats slot2 OV
        slot1_valid_i = 1; slot1_exc_i = 9'b000000010; slot1_pc_i = 32'h8000_1000;
        slot2_valid_i = 1; slot2_exc_i = 9'b000010000; slot2_pc_i = 32'h8000_1004; slot2_ds_i = 1;
        fire();
        expect_exc(1, 0);

        // Clean slot1, slot2 OV in a delay slot
        slot1_valid_i = 1; slot1_exc_i = 0; slot1_ds_i = 0;
        slot2_valid_i = 1; slot2_exc_i = 9'b000010000; slot2_pc_i = 32'h8000_1004; slot2_ds_i = 1;
        fire();
        expect_exc(0, 0);

        // ADEL data beats ADES data within one slot; data address passed through
        slot1_valid_i = 1; slot1_exc_i = 9'b011000000; slot2_ds_i = 0; mem_addr_i = 32'h8000_0003;
        fire();
        expect_exc(0, 0);

        // Interrupt attaches to slot2 when slot1 is not committing
        status_i = 32'h0000_0401; cause_i = 32'h0000_0400;
        slot1_pc_i = 32'h8000_2000; slot2_pc_i = 32'h8000_2004;
        slot2_valid_i = 1; slot2_exc_i = 0;
        fire();
        expect_exc(0, 0);

        // Pending interrupt with no committing slot waits
        fire();
        expect_none(3);

        // EXL set: interrupt masked
        status_i = 32'h0000_0403;
        slot2_valid_i = 1;
        fire();
        expect_none(3);
        status_i = 0; cause_i = 0;

        // ERET with ready held low 3 cycles; SYS offered during REDIRECT is ignored
        slot1_valid_i = 1; slot1_exc_i = 9'b100000000; slot1_pc_i = 32'h8000_3000;
        epc_i = 32'h8000_0040;
        fire();
        expect_exc(3, 1);
        expect_none(3);
        chk("sb_empty", sb.size(), 32'd0);

        // Reset in the middle of REDIRECT
        slot1_valid_i = 1; slot1_exc_i = 9'b000000100;
        fire();
        chk("mid_flush", {31'd0, flush_o}, 32'd1);
        sb.delete();
        @(negedge clk);
        chk("mid_rv", {31'd0, redirect_valid_o}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_rv", {31'd0, redirect_valid_o}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        chk("mid_rst_pc", redirect_pc_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_rv", {31'd0, redirect_valid_o | busy_o}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
